// File: rtl/du_pkg.sv
// Shared types and constants for the debug-unit frame transmitter.
// The CSUM state exists only when DU_TX_CHECKSUM_EN is defined.
package du_pkg;

  localparam logic [7:0] DU_HEADER     = 8'hA5;
  localparam int         DU_WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_FETCH = 3'd2,
    ST_BYTE  = 3'd3,
    ST_GAP   = 3'd4,
`ifdef DU_TX_CHECKSUM_EN
    ST_CSUM  = 3'd6,
`endif
    ST_DONE  = 3'd5
  } du_state_e;

  // Where GAP continues once the FIFO has had a cycle to update tx_full.
  typedef enum logic [1:0] {
    GAP_AFTER_HDR  = 2'd0,
    GAP_AFTER_DATA = 2'd1,
    GAP_AFTER_CSUM = 2'd2
  } du_gap_ret_e;

  function automatic int du_frame_len(input int n_words, input bit with_csum);
    return 1 + DU_WORD_BYTES * n_words + (with_csum ? 1 : 0);
  endfunction

endpackage

// File: rtl/du_byte_shifter.sv
// 32-bit word register that hands out bytes MSB first, with a 2-bit byte
// counter and a flag that rises once all four bytes have been taken.
module du_byte_shifter
  import du_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        shift,
  input  logic [31:0] din,
  output logic [7:0]  top_byte,
  output logic [1:0]  byte_cnt,
  output logic        word_done
);

  logic [31:0] shreg_q, shreg_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (load) begin
      shreg_d = din;
      cnt_d   = 2'd0;
      done_d  = 1'b0;
    end else if (shift) begin
      shreg_d = {shreg_q[23:0], 8'h00};
      cnt_d   = cnt_q + 2'd1;
      // The counter wraps on the fourth byte, so remember that the word is spent.
      if (cnt_q == 2'(DU_WORD_BYTES - 1)) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign top_byte  = shreg_q[31:24];
  assign byte_cnt  = cnt_q;
  assign word_done = done_q;

endmodule

// File: rtl/du_frame_tx.sv
// Debug-unit frame transmitter: header, N_WORDS big-endian words, into the UART TX FIFO.
// Define DU_TX_CHECKSUM_EN to append an XOR checksum byte covering the whole frame.
module du_frame_tx
  import du_pkg::*;
#(
  parameter int         DBIT    = 8,
  parameter int         N_WORDS = 16,
  parameter int         IDX_W   = 5,
  parameter logic [7:0] HEADER  = DU_HEADER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] word_idx,
  input  logic [31:0]      word_data,
  input  logic             tx_full,
  output logic [DBIT-1:0]  w_data,
  output logic             wr_uart,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  du_state_e        state_q, state_d;
  du_gap_ret_e      gap_ret_q, gap_ret_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [DBIT-1:0]  w_data_q, w_data_d;
  logic             wr_uart_q, wr_uart_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             to_done;

  logic             sh_load, sh_shift, sh_word_done;
  logic [7:0]       sh_top;
  logic [1:0]       sh_cnt;

`ifdef DU_TX_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  du_byte_shifter u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (sh_load),
    .shift    (sh_shift),
    .din      (word_data),
    .top_byte (sh_top),
    .byte_cnt (sh_cnt),
    .word_done(sh_word_done)
  );

  always_comb begin
    state_d    = state_q;
    gap_ret_d  = gap_ret_q;
    word_idx_d = word_idx_q;
    w_data_d   = w_data_q;
    wr_uart_d  = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    to_done    = 1'b0;
`ifdef DU_TX_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          word_idx_d = '0;
`ifdef DU_TX_CHECKSUM_EN
          csum_d     = 8'h00;
`endif
          state_d    = ST_HDR;
        end
      end

      ST_HDR: begin
        if (!tx_full) begin
          w_data_d  = DBIT'(HEADER);
          wr_uart_d = 1'b1;
          gap_ret_d = GAP_AFTER_HDR;
`ifdef DU_TX_CHECKSUM_EN
          csum_d    = csum_q ^ HEADER;
`endif
          state_d   = ST_GAP;
        end
      end

      ST_FETCH: begin
        sh_load = 1'b1;
        state_d = ST_BYTE;
      end

      ST_BYTE: begin
        if (!tx_full) begin
          w_data_d  = DBIT'(sh_top);
          wr_uart_d = 1'b1;
          sh_shift  = 1'b1;
          gap_ret_d = GAP_AFTER_DATA;
`ifdef DU_TX_CHECKSUM_EN
          csum_d    = csum_q ^ sh_top;
`endif
          state_d   = ST_GAP;
        end
      end

      // The idle cycle here keeps strobes apart and lets tx_full catch up.
      ST_GAP: begin
        case (gap_ret_q)
          GAP_AFTER_HDR:  state_d = ST_FETCH;
          GAP_AFTER_CSUM: to_done = 1'b1;
          default: begin
            if (!sh_word_done) begin
              state_d = ST_BYTE;
            end else if (word_idx_q < LAST_IDX) begin
              word_idx_d = word_idx_q + IDX_W'(1);
              state_d    = ST_FETCH;
            end else begin
`ifdef DU_TX_CHECKSUM_EN
              state_d = ST_CSUM;
`else
              to_done = 1'b1;
`endif
            end
          end
        endcase
      end

`ifdef DU_TX_CHECKSUM_EN
      ST_CSUM: begin
        if (!tx_full) begin
          w_data_d  = DBIT'(csum_q);
          wr_uart_d = 1'b1;
          gap_ret_d = GAP_AFTER_CSUM;
          state_d   = ST_GAP;
        end
      end
`endif

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    if (to_done) begin
      state_d    = ST_DONE;
      busy_d     = 1'b0;
      done_d     = 1'b1;
      word_idx_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gap_ret_q  <= GAP_AFTER_HDR;
      word_idx_q <= '0;
      w_data_q   <= '0;
      wr_uart_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DU_TX_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      gap_ret_q  <= gap_ret_d;
      word_idx_q <= word_idx_d;
      w_data_q   <= w_data_d;
      wr_uart_q  <= wr_uart_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef DU_TX_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign word_idx = word_idx_q;
  assign w_data   = w_data_q;
  assign wr_uart  = wr_uart_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_du_frame_tx.sv
// Scoreboard bench for du_frame_tx: a 2-word and a 16-word instance, checked
// against byte streams the bench builds from its own word tables.
module tb_du_frame_tx;

  int total = 0;
  int bad   = 0;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start2 = 1'b0, full2 = 1'b0;
  logic [4:0]  idx2;
  logic [31:0] word2;
  logic [7:0]  wd2;
  logic        wr2, busy2, done2;
  logic [31:0] mem2 [2];
  assign word2 = mem2[idx2[0]];

  logic        start16 = 1'b0, full16 = 1'b0, garble16 = 1'b0;
  logic [4:0]  idx16;
  logic [31:0] word16;
  logic [7:0]  wd16;
  logic        wr16, busy16, done16;
  logic [31:0] mem16 [16];
  logic        first_pend16 = 1'b0, hdr_prev16 = 1'b0;
  logic [4:0]  idx_prev16 = 5'd0;
  logic        fetch_win16;

  // The source word is only correct in the cycle the DUT should be fetching it.
  assign fetch_win16 = (idx16 != idx_prev16) || hdr_prev16;
  assign word16 = (garble16 && !fetch_win16) ? ~mem16[idx16[3:0]] : mem16[idx16[3:0]];

  du_frame_tx #(.DBIT(8), .N_WORDS(2), .IDX_W(5), .HEADER(8'hA5)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .word_idx(idx2), .word_data(word2),
    .tx_full(full2), .w_data(wd2), .wr_uart(wr2), .busy(busy2), .done(done2));

  du_frame_tx #(.DBIT(8), .N_WORDS(16), .IDX_W(5), .HEADER(8'hA5)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .word_idx(idx16), .word_data(word16),
    .tx_full(full16), .w_data(wd16), .wr_uart(wr16), .busy(busy16), .done(done16));

  logic [7:0] exp2_q[$], exp16_q[$];
  logic [7:0] obs2_q[$], obs16_q[$];
  int rd2 = 0, rd16 = 0;

  int cyc = 0;
  int viol2 = 0, viol16 = 0, busy_bad2 = 0;
  int done_cnt2 = 0, done_cnt16 = 0, start_cyc2 = 0, done_cyc2 = 0;
  int idx_steps16 = 0, idx_err16 = 0;
  logic pwr2 = 1'b0, pfull2 = 1'b0, pbusy2 = 1'b0, pwr16 = 1'b0, pfull16 = 1'b0;
  logic [4:0] last_idx16 = 5'd0;

  always @(posedge clk) begin
    idx_prev16 <= idx16;
    hdr_prev16 <= wr16 && first_pend16;
    if (start16 && !busy16) first_pend16 <= 1'b1;
    else if (wr16) first_pend16 <= 1'b0;
  end

  // Record every strobe and any handshake rule broken by either instance.
  always @(negedge clk) begin
    cyc++;
    if (wr2) begin
      obs2_q.push_back(wd2);
      if (pwr2 || pfull2) viol2++;
    end
    if (done2) begin
      done_cnt2++;
      done_cyc2 = cyc;
      if (busy2 || !pbusy2) busy_bad2++;
    end
    if (start2 && !busy2) start_cyc2 = cyc;
    if (wr16) begin
      obs16_q.push_back(wd16);
      if (pwr16 || pfull16) viol16++;
    end
    if (done16) done_cnt16++;
    if (idx16 != last_idx16) begin
      if (idx16 == last_idx16 + 5'd1) idx_steps16++;
      else if (idx16 != 5'd0) idx_err16++;
      last_idx16 = idx16;
    end
    pwr2 = wr2; pfull2 = full2; pbusy2 = busy2;
    pwr16 = wr16; pfull16 = full16;
  end

  task automatic push_frame2();
    logic [7:0] b, x;
    x = 8'hA5;
    exp2_q.push_back(8'hA5);
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = mem2[w][31-8*k -: 8];
        exp2_q.push_back(b);
        x ^= b;
      end
    end
`ifdef DU_TX_CHECKSUM_EN
    exp2_q.push_back(x);
`endif
  endtask

  task automatic drive_frame2(input int stall_at, input int restart_at, input int reset_at,
                              output bit timed_out, output int stall_seen);
    int  base, dbase;
    bit  stalled, restarted;
    base = obs2_q.size(); dbase = done_cnt2;
    stalled = 0; restarted = 0; timed_out = 1; stall_seen = -1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (reset_at > 0 && obs2_q.size() - base == reset_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        timed_out = 0;
        break;
      end
      if (stall_at > 0 && !stalled && obs2_q.size() - base == stall_at) begin
        full2 = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        stall_seen = obs2_q.size() - base;
        full2 = 1'b0;
        stalled = 1;
      end
      if (restart_at > 0 && !restarted && obs2_q.size() - base == restart_at) begin
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        restarted = 1;
      end
      if (done_cnt2 != dbase) begin
        timed_out = 0;
        break;
      end
    end
    if (reset_at == 0) begin
      repeat (12) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (idx2 !== 5'd0)  begin bad++; $display("[TB] FAIL rst_idx2 actual=%h required=00", idx2); end
    total++; if (wd2 !== 8'h00)  begin bad++; $display("[TB] FAIL rst_wdata2 actual=%h required=00", wd2); end
    total++; if (wr2 !== 1'b0)   begin bad++; $display("[TB] FAIL rst_wr2 actual=%b required=0", wr2); end
    total++; if (busy2 !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy2 actual=%b required=0", busy2); end
    total++; if (done2 !== 1'b0) begin bad++; $display("[TB] FAIL rst_done2 actual=%b required=0", done2); end
    total++; if (idx16 !== 5'd0) begin bad++; $display("[TB] FAIL rst_idx16 actual=%h required=00", idx16); end
    total++; if (wd16 !== 8'h00) begin bad++; $display("[TB] FAIL rst_wdata16 actual=%h required=00", wd16); end
    total++; if (wr16 !== 1'b0)  begin bad++; $display("[TB] FAIL rst_wr16 actual=%b required=0", wr16); end
    total++; if (busy16 !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy16 actual=%b required=0", busy16); end
    total++; if (done16 !== 1'b0) begin bad++; $display("[TB] FAIL rst_done16 actual=%b required=0", done16); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  int basic_base = 0, basic_count = 0;

  task automatic test_basic();
    bit timed_out; int ss, dbase, dur_req; logic [7:0] e;
    push_frame2();
    basic_base = obs2_q.size(); rd2 = basic_base; dbase = done_cnt2;
    drive_frame2(0, 0, 0, timed_out, ss);
    basic_count = obs2_q.size() - basic_base;
    total++; if (timed_out) begin bad++; $display("[TB] FAIL basic_timeout actual=no_done required=done"); end
    while (exp2_q.size() > 0) begin
      e = exp2_q.pop_front(); total++;
      if (rd2 >= obs2_q.size()) begin bad++; $display("[TB] FAIL basic_byte actual=none required=%h", e); end
      else begin
        if (obs2_q[rd2] !== e) begin bad++; $display("[TB] FAIL basic_byte%0d actual=%h required=%h", rd2 - basic_base, obs2_q[rd2], e); end
        rd2++;
      end
    end
    total++; if (obs2_q.size() != rd2) begin bad++; $display("[TB] FAIL basic_extra actual=%0d required=%0d", obs2_q.size(), rd2); rd2 = obs2_q.size(); end
    total++; if (done_cnt2 - dbase != 1) begin bad++; $display("[TB] FAIL basic_done_cnt actual=%0d required=1", done_cnt2 - dbase); end
`ifdef DU_TX_CHECKSUM_EN
    dur_req = 3 + 9 * 2 + 1 + 2;
`else
    dur_req = 3 + 9 * 2 + 1;
`endif
    total++; if (done_cyc2 - start_cyc2 + 1 != dur_req) begin bad++; $display("[TB] FAIL basic_duration actual=%0d required=%0d", done_cyc2 - start_cyc2 + 1, dur_req); end
    total++; if (viol2 != 0) begin bad++; $display("[TB] FAIL basic_strobe_rules actual=%0d required=0", viol2); end
    total++; if (busy_bad2 != 0) begin bad++; $display("[TB] FAIL basic_busy_with_done actual=%0d required=0", busy_bad2); end
  endtask

  task automatic test_checksum();
`ifdef DU_TX_CHECKSUM_EN
    total++; if (basic_count != 10) begin bad++; $display("[TB] FAIL csum_len actual=%0d required=10", basic_count); end
    total++;
    if (basic_count < 10) begin bad++; $display("[TB] FAIL csum_byte actual=none required=e1"); end
    else if (obs2_q[basic_base + 9] !== 8'hE1) begin bad++; $display("[TB] FAIL csum_byte actual=%h required=e1", obs2_q[basic_base + 9]); end
`else
    total++; if (basic_count != 9) begin bad++; $display("[TB] FAIL nocsum_len actual=%0d required=9", basic_count); end
    total++;
    if (basic_count < 9) begin bad++; $display("[TB] FAIL nocsum_last actual=none required=dd"); end
    else if (obs2_q[basic_base + 8] !== 8'hDD) begin bad++; $display("[TB] FAIL nocsum_last actual=%h required=dd", obs2_q[basic_base + 8]); end
`endif
  endtask

  task automatic test_stall();
    bit timed_out; int ss, base, dbase; logic [7:0] e;
    push_frame2();
    base = obs2_q.size(); rd2 = base; dbase = done_cnt2;
    drive_frame2(3, 0, 0, timed_out, ss);
    total++; if (timed_out) begin bad++; $display("[TB] FAIL stall_timeout actual=no_done required=done"); end
    total++; if (ss != 3) begin bad++; $display("[TB] FAIL stall_bytes_during actual=%0d required=3", ss); end
    while (exp2_q.size() > 0) begin
      e = exp2_q.pop_front(); total++;
      if (rd2 >= obs2_q.size()) begin bad++; $display("[TB] FAIL stall_byte actual=none required=%h", e); end
      else begin
        if (obs2_q[rd2] !== e) begin bad++; $display("[TB] FAIL stall_byte%0d actual=%h required=%h", rd2 - base, obs2_q[rd2], e); end
        rd2++;
      end
    end
    total++; if (obs2_q.size() != rd2) begin bad++; $display("[TB] FAIL stall_extra actual=%0d required=%0d", obs2_q.size(), rd2); rd2 = obs2_q.size(); end
    total++; if (done_cnt2 - dbase != 1) begin bad++; $display("[TB] FAIL stall_done_cnt actual=%0d required=1", done_cnt2 - dbase); end
    total++; if (viol2 != 0) begin bad++; $display("[TB] FAIL stall_strobe_rules actual=%0d required=0", viol2); end
  endtask

  task automatic test_back_to_back();
    bit timed_out; int ss, base, dbase; logic [7:0] e;
    push_frame2();
    base = obs2_q.size(); rd2 = base; dbase = done_cnt2;
    drive_frame2(0, 5, 0, timed_out, ss);
    total++; if (timed_out) begin bad++; $display("[TB] FAIL restart_timeout actual=no_done required=done"); end
    while (exp2_q.size() > 0) begin
      e = exp2_q.pop_front(); total++;
      if (rd2 >= obs2_q.size()) begin bad++; $display("[TB] FAIL restart_byte actual=none required=%h", e); end
      else begin
        if (obs2_q[rd2] !== e) begin bad++; $display("[TB] FAIL restart_byte%0d actual=%h required=%h", rd2 - base, obs2_q[rd2], e); end
        rd2++;
      end
    end
    total++; if (obs2_q.size() != rd2) begin bad++; $display("[TB] FAIL restart_extra actual=%0d required=%0d", obs2_q.size(), rd2); rd2 = obs2_q.size(); end
    total++; if (done_cnt2 - dbase != 1) begin bad++; $display("[TB] FAIL restart_done_cnt actual=%0d required=1", done_cnt2 - dbase); end
    total++; if (busy2 !== 1'b0) begin bad++; $display("[TB] FAIL restart_busy_after actual=%b required=0", busy2); end
  endtask

  task automatic test_reset_mid();
    bit timed_out; int ss, base, dbase; logic [7:0] e;
    push_frame2();
    base = obs2_q.size(); rd2 = base;
    drive_frame2(0, 0, 4, timed_out, ss);
    @(negedge clk);
    total++; if (obs2_q.size() - base != 4) begin bad++; $display("[TB] FAIL rstmid_bytes actual=%0d required=4", obs2_q.size() - base); end
    total++; if (wr2 !== 1'b0)   begin bad++; $display("[TB] FAIL rstmid_wr actual=%b required=0", wr2); end
    total++; if (busy2 !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy actual=%b required=0", busy2); end
    total++; if (idx2 !== 5'd0)  begin bad++; $display("[TB] FAIL rstmid_idx actual=%h required=00", idx2); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = exp2_q.pop_front(); total++;
      if (rd2 >= obs2_q.size()) begin bad++; $display("[TB] FAIL rstmid_byte actual=none required=%h", e); end
      else begin
        if (obs2_q[rd2] !== e) begin bad++; $display("[TB] FAIL rstmid_byte%0d actual=%h required=%h", i, obs2_q[rd2], e); end
        rd2++;
      end
    end
    exp2_q.delete();
    rd2 = obs2_q.size();
    @(posedge clk); #1;
    push_frame2();
    base = obs2_q.size(); dbase = done_cnt2;
    drive_frame2(0, 0, 0, timed_out, ss);
    total++; if (timed_out) begin bad++; $display("[TB] FAIL rstmid_new_timeout actual=no_done required=done"); end
    while (exp2_q.size() > 0) begin
      e = exp2_q.pop_front(); total++;
      if (rd2 >= obs2_q.size()) begin bad++; $display("[TB] FAIL rstmid_new_byte actual=none required=%h", e); end
      else begin
        if (obs2_q[rd2] !== e) begin bad++; $display("[TB] FAIL rstmid_new_byte%0d actual=%h required=%h", rd2 - base, obs2_q[rd2], e); end
        rd2++;
      end
    end
    total++; if (obs2_q.size() != rd2) begin bad++; $display("[TB] FAIL rstmid_new_extra actual=%0d required=%0d", obs2_q.size(), rd2); rd2 = obs2_q.size(); end
    total++; if (done_cnt2 - dbase != 1) begin bad++; $display("[TB] FAIL rstmid_new_done actual=%0d required=1", done_cnt2 - dbase); end
  endtask

  task automatic test_long_frame();
    bit timed_out; int base, dbase, steps0, err0, len_req; logic [7:0] b, x, e;
    for (int i = 0; i < 16; i++) mem16[i] = 32'(i) * 32'h0000_0100;
    x = 8'hA5;
    exp16_q.push_back(8'hA5);
    for (int w = 0; w < 16; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = mem16[w][31-8*k -: 8];
        exp16_q.push_back(b);
        x ^= b;
      end
    end
`ifdef DU_TX_CHECKSUM_EN
    exp16_q.push_back(x);
    len_req = 66;
`else
    len_req = 65;
`endif
    garble16 = 1'b1;
    base = obs16_q.size(); rd16 = base; dbase = done_cnt16;
    steps0 = idx_steps16; err0 = idx_err16;
    start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    timed_out = 1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (done_cnt16 != dbase) begin timed_out = 0; break; end
    end
    repeat (6) begin @(posedge clk); #1; end
    garble16 = 1'b0;
    total++; if (timed_out) begin bad++; $display("[TB] FAIL long_timeout actual=no_done required=done"); end
    total++; if (obs16_q.size() - base != len_req) begin bad++; $display("[TB] FAIL long_len actual=%0d required=%0d", obs16_q.size() - base, len_req); end
    while (exp16_q.size() > 0) begin
      e = exp16_q.pop_front(); total++;
      if (rd16 >= obs16_q.size()) begin bad++; $display("[TB] FAIL long_byte actual=none required=%h", e); end
      else begin
        if (obs16_q[rd16] !== e) begin bad++; $display("[TB] FAIL long_byte%0d actual=%h required=%h", rd16 - base, obs16_q[rd16], e); end
        rd16++;
      end
    end
    total++; if (done_cnt16 - dbase != 1) begin bad++; $display("[TB] FAIL long_done_cnt actual=%0d required=1", done_cnt16 - dbase); end
    total++; if (idx_steps16 - steps0 != 15) begin bad++; $display("[TB] FAIL long_idx_steps actual=%0d required=15", idx_steps16 - steps0); end
    total++; if (idx_err16 != err0) begin bad++; $display("[TB] FAIL long_idx_jumps actual=%0d required=%0d", idx_err16, err0); end
    total++; if (idx16 !== 5'd0) begin bad++; $display("[TB] FAIL long_idx_final actual=%h required=00", idx16); end
    total++; if (viol16 != 0) begin bad++; $display("[TB] FAIL long_strobe_rules actual=%0d required=0", viol16); end
  endtask

  initial begin
    mem2[0] = 32'h1122_3344;
    mem2[1] = 32'hAABB_CCDD;
    for (int i = 0; i < 16; i++) mem16[i] = 32'h0;
    test_reset();
    test_basic();
    test_checksum();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_long_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
